// File: rtl/residual_grad_mac.sv
// Serial gradient MAC: g = sum_i r[i]*x[i], one product per cycle, valid/ready output.
// Optional GRAD_SAT_EN: clamp the shifted accumulator to signed 32-bit and flag sat.
module residual_grad_mac #(
   parameter int M    = 20,
   parameter int FRAC = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*M-1:0]     residual,
   input  logic [32*M-1:0]     x_col,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         grad,
   output logic                busy,
   output logic                sat
);
   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
   localparam int AW    = 64 + $clog2(M) + 1;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [32*M-1:0]       r_q, x_q;
   logic signed [AW-1:0]  acc_q, acc_next, s;
   logic signed [31:0]    a, b;
   logic signed [63:0]    prod;
   logic [31:0]           grad_q, grad_d;
   logic                  sat_q, sat_d;
   logic                  last;

   assign last = (idx_q == IDX_W'(M - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = MAC;
         MAC:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);

   // Operand buses shift left each MAC cycle so the current element is always on top.
   assign a        = r_q[32*M-1 -: 32];
   assign b        = x_q[32*M-1 -: 32];
   assign prod     = 64'(a) * 64'(b);
   assign acc_next = acc_q + AW'(prod);
   assign s        = acc_next >>> FRAC;

   always_comb begin
      grad_d = s[31:0];
      sat_d  = 1'b0;
`ifdef GRAD_SAT_EN
      if (s > AW'(64'sd2147483647)) begin
         grad_d = 32'h7FFF_FFFF;
         sat_d  = 1'b1;
      end else if (s < AW'(-64'sd2147483648)) begin
         grad_d = 32'h8000_0000;
         sat_d  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '0;
         x_q    <= '0;
         acc_q  <= '0;
         idx_q  <= '0;
         grad_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               r_q   <= residual;
               x_q   <= x_col;
               acc_q <= '0;
               idx_q <= '0;
            end
            MAC: begin
               acc_q <= acc_next;
               r_q   <= r_q << 32;
               x_q   <= x_q << 32;
               idx_q <= last ? '0 : idx_q + IDX_W'(1);
               if (last) begin
                  grad_q <= grad_d;
                  sat_q  <= sat_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign grad = grad_q;
   assign sat  = sat_q;
endmodule
